quad_encoder_array: RTL and testbench

//  Parametrised multi-channel quadrature encoder front-end for motor feedback.
//  Per channel: synchronises raw SA/SB pins, glitch-filters them, decodes them in
//  x1/x2/x4 mode, and keeps a signed wrapping position count. Also outputs a

---
 rtl/quad_encoder_array.sv | 170 +++++++++++++++++
 tb/tb_quad_encoder_array.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_array.sv
// Multi-channel quadrature encoder front-end.
// Each channel synchronises its raw A/B pins, glitch-filters them, decodes
// x1/x2/x4 steps into a wrapping signed position, and accumulates steps over a
// shared window to produce a per-channel velocity sample. A both-phases-changed
// update is flagged in a sticky error bit and contributes no step.
module quad_encoder_array #(
    parameter int NCH         = 2,
    parameter int SYNC_STAGES = 3,
    parameter int FILT_LEN    = 4,
    parameter int CNT_W       = 32,
    parameter int CLK_FREQ    = 200_000_000,
    parameter int WIN_HZ      = 100
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NCH-1:0]       sa,
    input  logic [NCH-1:0]       sb,
    input  logic [1:0]           mode,
    input  logic [NCH-1:0]       invert,
    input  logic [NCH-1:0]       clr,
    input  logic [NCH-1:0]       err_clr,
    output logic [NCH*CNT_W-1:0] pos,
    output logic [NCH*CNT_W-1:0] vel,
    output logic                 vel_valid,
    output logic [NCH-1:0]       err
);

    localparam int WIN_CYC = CLK_FREQ / WIN_HZ;
    localparam int WIN_W   = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam int FC_W    = $clog2(FILT_LEN + 1);

    logic [WIN_W-1:0] r_win;
    logic             r_vel_valid;
    logic             w_win_last;

    assign w_win_last = (r_win == WIN_W'(WIN_CYC - 1));
    assign vel_valid  = r_vel_valid;

    // Free-running velocity window shared by all channels.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_win       <= '0;
            r_vel_valid <= 1'b0;
        end else begin
            r_vel_valid <= w_win_last;
            r_win       <= w_win_last ? '0 : r_win + 1'b1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync_a;
        logic [SYNC_STAGES-1:0] r_sync_b;
        logic [1:0]             w_syn;
        logic [1:0]             r_acc;
        logic [1:0]             r_prev;
        logic [FC_W-1:0]        r_fcnt [2];
        logic [1:0]             w_idx_old;
        logic [1:0]             w_idx_new;
        logic [1:0]             w_diff;
        logic                   w_fwd;
        logic                   w_rev;
        logic                   w_illegal;
        logic                   w_a_chg;
        logic [1:0]             w_step_raw;
        logic [1:0]             w_step;
        logic [CNT_W-1:0]       w_step_ext;
        logic [CNT_W-1:0]       r_pos;
        logic [CNT_W-1:0]       r_vacc;
        logic [CNT_W-1:0]       r_vel;
        logic                   r_err;

        // Raw pins pass through a plain flop chain; nothing reads the early stages.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_sync_a <= '0;
                r_sync_b <= '0;
            end else begin
                r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], sa[i]};
                r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], sb[i]};
            end
        end

        // Bit 1 is phase A, bit 0 is phase B throughout the decoder.
        assign w_syn = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};

        // Per-bit persistence filter: a new level must be seen FILT_LEN cycles in a row.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_acc <= 2'b00;
                for (int b = 0; b < 2; b++) r_fcnt[b] <= '0;
            end else begin
                for (int b = 0; b < 2; b++) begin
                    if (w_syn[b] == r_acc[b]) begin
                        r_fcnt[b] <= '0;
                    end else if (r_fcnt[b] == FC_W'(FILT_LEN - 1)) begin
                        r_acc[b]  <= w_syn[b];
                        r_fcnt[b] <= '0;
                    end else begin
                        r_fcnt[b] <= r_fcnt[b] + 1'b1;
                    end
                end
            end
        end

        // Gray-to-binary phase index: 00->0, 10->1, 11->2, 01->3 so forward is +1.
        assign w_idx_old = {r_prev[0], r_prev[1] ^ r_prev[0]};
        assign w_idx_new = {r_acc[0], r_acc[1] ^ r_acc[0]};
        assign w_diff    = w_idx_new - w_idx_old;
        assign w_fwd     = (w_diff == 2'd1);
        assign w_rev     = (w_diff == 2'd3);
        assign w_illegal = (w_diff == 2'd2);
        assign w_a_chg   = r_prev[1] ^ r_acc[1];

        // Step decode for the selected resolution; 2'b01 = +1, 2'b11 = -1.
        always_comb begin
            w_step_raw = 2'b00;
            case (mode)
                2'd0: begin
                    if (w_a_chg && r_acc[1] && !w_illegal)
                        w_step_raw = r_acc[0] ? 2'b11 : 2'b01;
                end
                2'd1: begin
                    if (w_a_chg && !w_illegal)
                        w_step_raw = w_fwd ? 2'b01 : 2'b11;
                end
                default: begin
                    if (w_fwd)
                        w_step_raw = 2'b01;
                    else if (w_rev)
                        w_step_raw = 2'b11;
                end
            endcase
            w_step = invert[i] ? (~w_step_raw + 2'b01) : w_step_raw;
        end

        assign w_step_ext = {{(CNT_W-2){w_step[1]}}, w_step};

        // Position, velocity accumulator and sticky error update.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_prev <= 2'b00;
                r_pos  <= '0;
                r_vacc <= '0;
                r_vel  <= '0;
                r_err  <= 1'b0;
            end else begin
                r_prev <= r_acc;
                if (clr[i])
                    r_pos <= '0;
                else
                    r_pos <= r_pos + w_step_ext;
                if (w_win_last) begin
                    r_vel  <= r_vacc + w_step_ext;
                    r_vacc <= '0;
                end else begin
                    r_vacc <= r_vacc + w_step_ext;
                end
                if (err_clr[i])
                    r_err <= 1'b0;
                else if (w_illegal)
                    r_err <= 1'b1;
            end
        end

        assign pos[i*CNT_W +: CNT_W] = r_pos;
        assign vel[i*CNT_W +: CNT_W] = r_vel;
        assign err[i]                = r_err;
    end

endmodule

// File: tb/tb_quad_encoder_array.sv
// Directed bench for quad_encoder_array: decode table plus hand-timed
// sequences for latency, glitch rejection, illegal transitions, wrap and velocity.
module tb_quad_encoder_array;

    logic        clk;
    logic        rstn;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [1:0]  mode;
    logic [1:0]  invert;
    logic [1:0]  clr;
    logic [1:0]  err_clr;
    logic [31:0] pos;
    logic [31:0] vel;
    logic        vel_valid;
    logic [1:0]  err;

    logic [0:0]  w_sa;
    logic [0:0]  w_sb;
    logic [0:0]  w_zero;
    logic [7:0]  w_pos;
    logic [7:0]  w_vel;
    logic        w_vv;
    logic [0:0]  w_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  mode;
        logic        inv;
        logic        a;
        logic        b;
        logic [15:0] exp_pos;
    } vec_t;

    vec_t tbl[$];

    quad_encoder_array #(
        .NCH(2), .SYNC_STAGES(3), .FILT_LEN(4), .CNT_W(16),
        .CLK_FREQ(1000), .WIN_HZ(10)
    ) dut (
        .clk(clk), .rstn(rstn), .sa(sa), .sb(sb), .mode(mode),
        .invert(invert), .clr(clr), .err_clr(err_clr),
        .pos(pos), .vel(vel), .vel_valid(vel_valid), .err(err)
    );

    // Narrow single-channel instance so the signed wrap is reachable quickly.
    quad_encoder_array #(
        .NCH(1), .SYNC_STAGES(3), .FILT_LEN(4), .CNT_W(8),
        .CLK_FREQ(1000), .WIN_HZ(10)
    ) dut_w (
        .clk(clk), .rstn(rstn), .sa(w_sa), .sb(w_sb), .mode(mode),
        .invert(w_zero), .clr(w_zero), .err_clr(w_zero),
        .pos(w_pos), .vel(w_vel), .vel_valid(w_vv), .err(w_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] m, input logic inv, input logic a,
                                input logic b, input int p);
        vec_t v;
        v.mode    = m;
        v.inv     = inv;
        v.a       = a;
        v.b       = b;
        v.exp_pos = 16'(p);
        return v;
    endfunction

    // Phase k of the forward sequence 00,10,11,01 as {A,B}.
    function automatic logic [1:0] phase(input int k);
        int idx;
        idx = k % 4;
        return {(idx == 1 || idx == 2), (idx == 2 || idx == 3)};
    endfunction

    initial begin
        logic [1:0] ph;

        // x4 forward continuing from pos 1 at phase 10
        tbl.push_back(mk(2, 0, 1, 1, 2));
        tbl.push_back(mk(2, 0, 0, 1, 3));
        tbl.push_back(mk(2, 0, 0, 0, 4));
        tbl.push_back(mk(2, 0, 1, 0, 5));
        tbl.push_back(mk(2, 0, 1, 1, 6));
        tbl.push_back(mk(2, 0, 0, 1, 7));
        tbl.push_back(mk(2, 0, 0, 0, 8));
        // x1 forward: only 00->10 counts
        for (int c = 0; c < 4; c++) begin
            tbl.push_back(mk(0, 0, 1, 0, 9 + c));
            tbl.push_back(mk(0, 0, 1, 1, 9 + c));
            tbl.push_back(mk(0, 0, 0, 1, 9 + c));
            tbl.push_back(mk(0, 0, 0, 0, 9 + c));
        end
        // x2 forward: A edges count
        for (int c = 0; c < 4; c++) begin
            tbl.push_back(mk(1, 0, 1, 0, 13 + 2*c));
            tbl.push_back(mk(1, 0, 1, 1, 13 + 2*c));
            tbl.push_back(mk(1, 0, 0, 1, 14 + 2*c));
            tbl.push_back(mk(1, 0, 0, 0, 14 + 2*c));
        end
        // x4 reverse with invert counts up
        tbl.push_back(mk(2, 1, 0, 1, 21));
        tbl.push_back(mk(2, 1, 1, 1, 22));
        tbl.push_back(mk(2, 1, 1, 0, 23));
        tbl.push_back(mk(2, 1, 0, 0, 24));
        // x4 reverse counts down
        tbl.push_back(mk(2, 0, 0, 1, 23));
        tbl.push_back(mk(2, 0, 1, 1, 22));
        tbl.push_back(mk(2, 0, 1, 0, 21));
        tbl.push_back(mk(2, 0, 0, 0, 20));
        // x1 reverse: A rising with B high is -1
        tbl.push_back(mk(0, 0, 0, 1, 20));
        tbl.push_back(mk(0, 0, 1, 1, 19));
        tbl.push_back(mk(0, 0, 1, 0, 19));
        tbl.push_back(mk(0, 0, 0, 0, 19));
        // x2 reverse with invert
        tbl.push_back(mk(1, 1, 0, 1, 19));
        tbl.push_back(mk(1, 1, 1, 1, 20));
        tbl.push_back(mk(1, 1, 1, 0, 20));
        tbl.push_back(mk(1, 1, 0, 0, 21));

        rstn = 1'b0; sa = '0; sb = '0; mode = 2'd2; invert = '0; clr = '0; err_clr = '0;
        w_sa = '0; w_sb = '0; w_zero = '0;
        tick(3);
        check("rst_pos", pos, 32'h0);
        check("rst_vel", vel, 32'h0);
        check("rst_err", {30'h0, err}, 32'h0);
        check("rst_vv", {31'h0, vel_valid}, 32'h0);
        rstn = 1'b1;
        tick(2);

        // Latency: first accepted change lands on the 8th edge
        sa[0] = 1'b1;
        tick(7);
        check("latency_edge7", {16'h0, pos[15:0]}, 32'd0);
        tick(1);
        check("latency_edge8", {16'h0, pos[15:0]}, 32'd1);
        tick(2);

        foreach (tbl[k]) begin
            mode      = tbl[k].mode;
            invert[0] = tbl[k].inv;
            sa[0]     = tbl[k].a;
            sb[0]     = tbl[k].b;
            tick(10);
            check($sformatf("tbl_%0d_pos0", k), {16'h0, pos[15:0]}, {16'h0, tbl[k].exp_pos});
        end
        invert = '0;
        mode   = 2'd2;
        check("pos1_idle", {16'h0, pos[31:16]}, 32'd0);
        check("err_after_tbl", {30'h0, err}, 32'h0);

        // Glitch rejection
        sa[0] = 1'b1; tick(3); sa[0] = 1'b0; tick(12);
        check("glitch3_pos", {16'h0, pos[15:0]}, 32'd21);
        check("glitch3_err", {31'h0, err[0]}, 32'd0);
        sa[0] = 1'b1; tick(4); sa[0] = 1'b0; tick(5);
        check("pulse4_pos", {16'h0, pos[15:0]}, 32'd22);
        tick(10);
        check("pulse4_back", {16'h0, pos[15:0]}, 32'd21);

        // Illegal 00->11
        sa[0] = 1'b1; sb[0] = 1'b1; tick(10);
        check("illegal_pos", {16'h0, pos[15:0]}, 32'd21);
        check("illegal_err", {31'h0, err[0]}, 32'd1);
        tick(5);
        check("err_sticky", {31'h0, err[0]}, 32'd1);
        err_clr[0] = 1'b1; tick(1); err_clr[0] = 1'b0;
        check("err_clr", {31'h0, err[0]}, 32'd0);
        sa[0] = 1'b0; tick(10);
        sb[0] = 1'b0; tick(10);
        check("after_illegal_fwd", {16'h0, pos[15:0]}, 32'd23);
        // err_clr coincident with an illegal update
        sa[0] = 1'b1; sb[0] = 1'b1; tick(7);
        err_clr[0] = 1'b1; tick(1); err_clr[0] = 1'b0;
        check("err_clr_wins", {31'h0, err[0]}, 32'd0);
        tick(3);
        check("err_clr_wins_hold", {31'h0, err[0]}, 32'd0);
        sa[0] = 1'b0; tick(10);
        sb[0] = 1'b0; tick(10);
        check("pos_before_clr", {16'h0, pos[15:0]}, 32'd25);

        // clr coincident with a step, then 0-1 wrap
        sa[0] = 1'b1; tick(7);
        clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
        check("clr_wins", {16'h0, pos[15:0]}, 32'd0);
        tick(5);
        check("clr_hold", {16'h0, pos[15:0]}, 32'd0);
        sa[0] = 1'b0; tick(10);
        check("wrap_neg", {16'h0, pos[15:0]}, 32'h0000_FFFF);
        clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
        check("clr_plain", {16'h0, pos[15:0]}, 32'd0);

        // Positive wrap on the 8-bit instance
        for (int k = 1; k <= 127; k++) begin
            ph = phase(k);
            w_sa[0] = ph[1]; w_sb[0] = ph[0];
            tick(6);
        end
        tick(4);
        check("w_pos_max", {24'h0, w_pos}, 32'h7F);
        ph = phase(128);
        w_sa[0] = ph[1]; w_sb[0] = ph[0];
        tick(10);
        check("w_pos_wrap", {24'h0, w_pos}, 32'h80);

        // Velocity windows from a fresh reset
        rstn = 1'b0; sa = '0; sb = '0; w_sa = '0; w_sb = '0;
        tick(2);
        rstn = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            ph = phase(k);
            sa[0] = ph[1]; sb[0] = ph[0];
            tick(10);
        end
        tick(49);
        check("vv_edge99", {31'h0, vel_valid}, 32'd0);
        check("vel0_edge99", {16'h0, vel[15:0]}, 32'd0);
        tick(1);
        check("vv_edge100", {31'h0, vel_valid}, 32'd1);
        check("vel0_win1", {16'h0, vel[15:0]}, 32'd5);
        check("vel1_win1", {16'h0, vel[31:16]}, 32'd0);
        tick(1);
        check("vv_pulse_end", {31'h0, vel_valid}, 32'd0);
        check("vel0_held", {16'h0, vel[15:0]}, 32'd5);
        tick(99);
        check("vv_win2", {31'h0, vel_valid}, 32'd1);
        check("vel0_win2", {16'h0, vel[15:0]}, 32'd0);
        tick(92);
        ph = phase(6);
        sa[0] = ph[1]; sb[0] = ph[0];
        tick(7);
        check("vv_edge299", {31'h0, vel_valid}, 32'd0);
        tick(1);
        check("vel0_last_cycle_step", {16'h0, vel[15:0]}, 32'd1);
        check("pos0_win3", {16'h0, pos[15:0]}, 32'd6);
        sa[1] = 1'b1; sb[1] = 1'b1;
        tick(10);
        check("err1_set", {31'h0, err[1]}, 32'd1);
        tick(20);

        // Asynchronous reset mid-window
        #2;
        rstn = 1'b0; sa = '0; sb = '0;
        #1;
        check("async_pos", pos, 32'h0);
        check("async_vel", vel, 32'h0);
        check("async_vv", {31'h0, vel_valid}, 32'd0);
        check("async_err", {30'h0, err}, 32'h0);
        tick(2);
        rstn = 1'b1;
        tick(99);
        check("vv_after_rst_99", {31'h0, vel_valid}, 32'd0);
        tick(1);
        check("vv_after_rst_100", {31'h0, vel_valid}, 32'd1);
        check("vel0_after_rst", {16'h0, vel[15:0]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
